// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
// The master drives requests and out_ready; the slave is the encoder itself.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32/RV64 base-format instruction encoder with a one-word output register.
// Out-of-range ADDI immediates expand into a LUI+ADDI pair.
module instr_encoder (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);

  localparam logic [6:0]  OpLui    = 7'b0110111;
  localparam logic [6:0]  OpOpImm  = 7'b0010011;
  localparam logic [31:0] NopWord  = 32'h0000_0013;

  typedef enum logic [1:0] {StEmpty, StFull, StFirst} state_e;

  state_e      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_addi;
  logic        r_err;
  logic        r_out_valid;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic        w_u_ok;
  logic        w_exp_range;
  logic        w_addi_op;
  logic [19:0] w_hi;
  logic [31:0] w_i_word;
  logic [31:0] w_s_word;
  logic [31:0] w_sb_word;
  logic [31:0] w_u_word;
  logic [31:0] w_uj_word;
  logic [31:0] w_lui;
  logic [31:0] w_addi;
  logic [31:0] w_word;
  logic        w_err;
  logic        w_expand;

  // Sign-extension checks: all bits above the field's sign bit must match it.
  assign w_fits12 = (&bus.imm[63:11]) | ~(|bus.imm[63:11]);
  assign w_fits13 = (&bus.imm[63:12]) | ~(|bus.imm[63:12]);
  assign w_fits21 = (&bus.imm[63:20]) | ~(|bus.imm[63:20]);
  assign w_u_ok   = (bus.imm[11:0] == 12'h000) &&
                    ((&bus.imm[63:31]) | ~(|bus.imm[63:31]));

  assign w_exp_range = ($signed(bus.imm) >= -64'sd2147483648) &&
                       ($signed(bus.imm) <= 64'sd2147481599);
  assign w_addi_op   = (bus.opcode == OpOpImm) && (bus.funct3 == 3'b000);

  // Rounding hi by the low-half sign bit equals (imm + 0x800) >> 12.
  assign w_hi = bus.imm[31:12] + {19'd0, bus.imm[11]};

  assign w_i_word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
  assign w_s_word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
  assign w_sb_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};
  assign w_u_word  = {bus.imm[31:12], bus.rd, bus.opcode};
  assign w_uj_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, bus.opcode};
  assign w_lui     = {w_hi, bus.rd, OpLui};
  assign w_addi    = {bus.imm[11:0], bus.rd, 3'b000, bus.rd, OpOpImm};

  always_comb begin
    w_word   = NopWord;
    w_err    = 1'b1;
    w_expand = 1'b0;
    case (bus.fmt)
      3'd0: begin
        if (w_fits12) begin
          w_word = w_i_word;
          w_err  = 1'b0;
        end else if (w_addi_op && w_exp_range) begin
          w_expand = 1'b1;
          w_err    = 1'b0;
        end
      end
      3'd1: begin
        if (w_fits12) begin
          w_word = w_s_word;
          w_err  = 1'b0;
        end
      end
      3'd2: begin
        if (w_fits13 && !bus.imm[0]) begin
          w_word = w_sb_word;
          w_err  = 1'b0;
        end
      end
      3'd3: begin
        if (w_u_ok) begin
          w_word = w_u_word;
          w_err  = 1'b0;
        end
      end
      3'd4: begin
        if (w_fits21 && !bus.imm[0]) begin
          w_word = w_uj_word;
          w_err  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign w_in_ready = (r_state == StEmpty) || ((r_state == StFull) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StEmpty;
      r_instr     <= 32'h0000_0000;
      r_addi      <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StFirst: begin
          if (bus.out_ready) begin
            r_state <= StFull;
            r_instr <= r_addi;
            r_err   <= 1'b0;
          end
        end
        default: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            if (w_expand) begin
              r_state <= StFirst;
              r_instr <= w_lui;
              r_addi  <= w_addi;
              r_err   <= 1'b0;
            end else begin
              r_state <= StFull;
              r_instr <= w_word;
              r_err   <= w_err;
            end
          end else if ((r_state == StFull) && bus.out_ready) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.instr     = r_instr;
  assign bus.err       = r_err;

endmodule
